divider: RTL
============

// Module: divider
//
// PURPOSE
//  Sequential RV32M divide unit (DIV, DIVU, REM, REMU): radix-2 restoring
//  shift-subtract, one quotient bit per clock. Sits beside the ALU shifter in
//  the execute stage and uses the same issue/stall contract: operands held by
//  the pipeline, o_busy stalls it, and the result is read when o_busy drops.
//
// PARAMETERS
//  XLEN       32  operand/result width; iteration count equals XLEN
//  EARLY_OUT   1  1: divide-by-zero and signed overflow finish without CALC
//
// PORTS
//  i_clk_n     in   1     clock; all state updates on rising edge
//  i_rst_n     in   1     asynchronous active-low reset
//  i_in_a      in   XLEN  dividend (rs1), held stable while o_busy=1
//  i_in_b      in   XLEN  divisor (rs2), held stable while o_busy=1
//  i_funct3    in   3     100 DIV, 101 DIVU, 110 REM, 111 REMU
//  i_div_en    in   1     M-extension op present in execute
//  o_result    out  XLEN  quotient or remainder, registered
//  o_busy      out  1     stall request
//
// BEHAVIOUR
//  - start = i_div_en && i_funct3[2]. signed = !funct3[0]; rem_sel = funct3[1].
//  - FSM states: IDLE, CALC, DONE.
//  - IDLE: when start, latch |a| and |b| (signed ops only; DIVU/REMU raw),
//    neg_q = signed & (a[31]^b[31]), neg_r = signed & a[31], and rem_sel.
//    Clear remainder, load count = XLEN-1, go to CALC.
//    If EARLY_OUT and b==0 -> load special result, go to DONE.
//    If EARLY_OUT, signed, a==0x80000000 and b==all-ones -> load special
//    result, go to DONE.
//  - CALC: rem' = {rem[XLEN-2:0], dividend msb}; if rem' >= divisor, subtract
//    it and shift in q=1, else shift in q=0. Dividend shifts left 1 per cycle.
//    At count==0: write result to o_result and go to DONE; else decrement count.
//  - Result = rem_sel ? remainder : quotient. Negate it when neg_r/neg_q
//    (two's complement, mod 2^XLEN).
//  - DONE: o_result valid, o_busy=0, and the pipeline advances at this edge.
//    Always go to IDLE next; start is ignored in DONE (it is the same
//    instruction).
//  - o_busy = (IDLE && start) || CALC. This is combinational, so the stall is
//    raised in the issue cycle.
//  - Latency, normal path: o_busy high for XLEN+1 cycles (33), then one DONE
//    cycle. Special path: busy for 1 cycle, then DONE.
//  - Special results (spec-mandated, also reached with EARLY_OUT=0):
//      b==0                  -> quotient all-ones, remainder = a
//      signed 0x80000000/-1  -> quotient 0x80000000, remainder 0
//  - Back-to-back: a start in the IDLE cycle after DONE begins a new op.
//  - o_result holds its last value outside DONE and is not cleared by a new
//    start until written.
//  - Reset (any state, including mid-CALC): state=IDLE, o_busy=0,
//    o_result=0, count=0, all datapath registers 0. No partial result leaks.
//  - i_div_en dropping mid-CALC (flush): the op completes normally; the
//    result is ignored by the pipeline.
//
// TESTING
//  1. DIVU a=100 b=7 -> o_result=14; REMU -> 2; o_busy high exactly 33 cycles.
//  2. DIV a=-7 (0xFFFFFFF9) b=2 -> 0xFFFFFFFD (-3); REM -> 0xFFFFFFFF (-1);
//     DIV a=7 b=-2 -> -3, REM -> 1.
//  3. DIV/DIVU a=0x12345678 b=0 -> 0xFFFFFFFF; REM/REMU -> 0x12345678;
//     o_busy high exactly 1 cycle.
//  4. DIV a=0x80000000 b=0xFFFFFFFF -> 0x80000000; REM -> 0; DIVU same
//     operands -> 0x00000000 via full CALC.
//  5. Back-to-back DIVU 0xFFFFFFFF/1 then REMU 0xFFFFFFFF/0x10 -> 0xFFFFFFFF
//     then 0xF; second op starts the cycle after DONE.
//  6. Assert i_rst_n=0 at CALC cycle 10 -> o_busy=0 and o_result=0
//     immediately (async); after release, a new DIVU 9/3 -> 3.

Source files
------------

// File: rtl/divider.sv
// Sequential RV32M divide unit (DIV/DIVU/REM/REMU).
// Radix-2 restoring shift-subtract, one quotient bit per clock.
`default_nettype none

module divider #(
  parameter int XLEN      = 32,
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic            i_clk_n,
  input  logic            i_rst_n,
  input  logic [XLEN-1:0] i_in_a,
  input  logic [XLEN-1:0] i_in_b,
  input  logic [2:0]      i_funct3,
  input  logic            i_div_en,
  output logic [XLEN-1:0] o_result,
  output logic            o_busy
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [XLEN-1:0] dividend;
  logic [XLEN-1:0] divisor;
  logic [XLEN-1:0] rem;
  logic [CW-1:0]   count;
  logic            neg_q;
  logic            neg_r;
  logic            rem_sel;

  logic            start;
  logic            is_signed;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_abs;
  logic [XLEN-1:0] b_abs;
  logic            b_zero;
  logic            overflow;
  logic [XLEN-1:0] special_res;

  assign start     = i_div_en & i_funct3[2];
  assign is_signed = ~i_funct3[0];
  assign a_neg     = is_signed & i_in_a[XLEN-1];
  assign b_neg     = is_signed & i_in_b[XLEN-1];
  assign a_abs     = a_neg ? -i_in_a : i_in_a;
  assign b_abs     = b_neg ? -i_in_b : i_in_b;
  assign b_zero    = (i_in_b == '0);
  assign overflow  = is_signed & (i_in_a == MIN_NEG) & (i_in_b == '1);

  always_comb begin
    special_res = '0;
    if (b_zero)
      special_res = i_funct3[1] ? i_in_a : '1;
    else
      special_res = i_funct3[1] ? '0 : MIN_NEG;
  end

  // One restoring step; the extra top bit keeps the compare exact when the
  // divisor has its MSB set.
  logic [XLEN:0]   rem_sh;
  logic [XLEN:0]   diff;
  logic            q_bit;
  logic [XLEN-1:0] rem_next;
  logic [XLEN-1:0] quo_next;
  logic [XLEN-1:0] res_mag;
  logic [XLEN-1:0] res_final;

  assign rem_sh    = {rem, dividend[XLEN-1]};
  assign diff      = rem_sh - {1'b0, divisor};
  assign q_bit     = ~diff[XLEN];
  assign rem_next  = q_bit ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
  assign quo_next  = {dividend[XLEN-2:0], q_bit};
  assign res_mag   = rem_sel ? rem_next : quo_next;
  assign res_final = (rem_sel ? neg_r : neg_q) ? -res_mag : res_mag;

  assign o_busy = i_rst_n & (((state == IDLE) & start) | (state == CALC));

  always_ff @(posedge i_clk_n or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      dividend <= '0;
      divisor  <= '0;
      rem      <= '0;
      count    <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      rem_sel  <= 1'b0;
      o_result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            dividend <= a_abs;
            divisor  <= b_abs;
            rem      <= '0;
            count    <= CW'(XLEN-1);
            // Division by zero keeps the all-ones quotient unsigned-looking.
            neg_q    <= (a_neg ^ b_neg) & ~b_zero;
            neg_r    <= a_neg;
            rem_sel  <= i_funct3[1];
            if (EARLY_OUT && (b_zero || overflow)) begin
              o_result <= special_res;
              state    <= DONE;
            end else begin
              state    <= CALC;
            end
          end
        end
        CALC: begin
          rem      <= rem_next;
          dividend <= quo_next;
          if (count == '0) begin
            o_result <= res_final;
            state    <= DONE;
          end else begin
            count <= count - 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
